// File: rtl/apb_master_pkg.sv
// apb_master_pkg: shared types and constants for the APB initiator.
//   apb_state_e  - transfer FSM states
//   APB_ADDR_W   - slave-local address width
//   APB_DATA_W   - data bus width
//   sel_onehot() - one-hot slave select for a slave index
package apb_master_pkg;

  localparam int unsigned APB_ADDR_W = 8;
  localparam int unsigned APB_DATA_W = 32;
  localparam int unsigned MAX_SLV    = 16;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp
  } apb_state_e;

  function automatic logic [MAX_SLV-1:0] sel_onehot(input logic [3:0] idx);
    logic [MAX_SLV-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/apb_rsp_mux.sv
// apb_rsp_mux: selects one slave's return path (PRDATA/PREADY/PSLVERR) by index.
// Ports:
//   sel_i        - registered slave index
//   prdata_i     - concatenated per-slave read data, slave k at [32k+31:32k]
//   pready_i     - per-slave ready
//   pslverr_i    - per-slave error
//   prdata_o     - selected read data (0 for an index with no slave)
//   pready_o     - selected ready
//   pslverr_o    - selected error
module apb_rsp_mux
  import apb_master_pkg::*;
#(
  parameter int unsigned NUM_SLV = 4,
  parameter int unsigned SEL_W   = 2
) (
  input  logic [SEL_W-1:0]              sel_i,
  input  logic [APB_DATA_W*NUM_SLV-1:0] prdata_i,
  input  logic [NUM_SLV-1:0]            pready_i,
  input  logic [NUM_SLV-1:0]            pslverr_i,
  output logic [APB_DATA_W-1:0]         prdata_o,
  output logic                          pready_o,
  output logic                          pslverr_o
);

  always_comb begin
    prdata_o  = '0;
    pready_o  = 1'b0;
    pslverr_o = 1'b0;
    for (int unsigned k = 0; k < NUM_SLV; k++) begin
      if (32'(sel_i) == k) begin
        prdata_o  = prdata_i[k*APB_DATA_W +: APB_DATA_W];
        pready_o  = pready_i[k];
        pslverr_o = pslverr_i[k];
      end
    end
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: APB3 initiator. Accepts single read/write commands over a
// valid/ready handshake, runs SETUP/ACCESS (with PREADY wait states) to the slave
// addressed by cmd_addr's upper bits, and returns a one-cycle response pulse.
// Out-of-range slave indices are answered with an error without touching the bus.
// Ports:
//   PCLK, PRESET         - clock, asynchronous active-high reset
//   cmd_valid/cmd_ready  - command handshake
//   cmd_write, cmd_addr  - direction, {slave index, 8-bit PADDR}
//   cmd_wdata            - write data
//   rsp_valid, rsp_rdata, rsp_err - response pulse, read data, error
//   PSEL..PWDATA         - APB request side
//   PRDATA/PREADY/PSLVERR - per-slave APB return side
// Build option: define APB_MASTER_TIMEOUT_EN to bound the ACCESS phase to TIMEOUT_CYC
// cycles; otherwise ACCESS waits for PREADY indefinitely.
module apb_master_ctrl
  import apb_master_pkg::*;
#(
  parameter int unsigned NUM_SLV     = 4,
  parameter int unsigned SEL_W       = 2,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [APB_ADDR_W+SEL_W-1:0]   cmd_addr,
  input  logic [APB_DATA_W-1:0]         cmd_wdata,
  output logic                          rsp_valid,
  output logic [APB_DATA_W-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic [NUM_SLV-1:0]            PSEL,
  output logic                          PENABLE,
  output logic                          PWRITE,
  output logic [APB_ADDR_W-1:0]         PADDR,
  output logic [APB_DATA_W-1:0]         PWDATA,
  input  logic [APB_DATA_W*NUM_SLV-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]            PREADY,
  input  logic [NUM_SLV-1:0]            PSLVERR
);

  apb_state_e              state_q;
  logic [SEL_W-1:0]        sel_q;
  logic [NUM_SLV-1:0]      psel_q;
  logic                    penable_q;
  logic                    pwrite_q;
  logic [APB_ADDR_W-1:0]   paddr_q;
  logic [APB_DATA_W-1:0]   pwdata_q;
  logic                    rsp_valid_q;
  logic [APB_DATA_W-1:0]   rsp_rdata_q;
  logic                    rsp_err_q;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned ToW = (TIMEOUT_CYC > 255) ? 16 : 8;
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYC - 1);
  logic [ToW-1:0] to_cnt_q;
`endif

  logic [SEL_W-1:0]      cmd_idx;
  logic                  cmd_idx_ok;
  logic [NUM_SLV-1:0]    cmd_oh;
  logic [APB_DATA_W-1:0] sel_prdata;
  logic                  sel_pready;
  logic                  sel_pslverr;

  assign cmd_idx    = cmd_addr[APB_ADDR_W+SEL_W-1:APB_ADDR_W];
  assign cmd_idx_ok = 32'(cmd_idx) < NUM_SLV;
  assign cmd_oh     = NUM_SLV'(sel_onehot(4'(cmd_idx)));

  apb_rsp_mux #(
    .NUM_SLV (NUM_SLV),
    .SEL_W   (SEL_W)
  ) u_rsp_mux (
    .sel_i     (sel_q),
    .prdata_i  (PRDATA),
    .pready_i  (PREADY),
    .pslverr_i (PSLVERR),
    .prdata_o  (sel_prdata),
    .pready_o  (sel_pready),
    .pslverr_o (sel_pslverr)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= StIdle;
      sel_q       <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      // Response fields form a single-cycle pulse unless set below.
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            if (cmd_idx_ok) begin
              state_q  <= StSetup;
              sel_q    <= cmd_idx;
              psel_q   <= cmd_oh;
              pwrite_q <= cmd_write;
              paddr_q  <= cmd_addr[APB_ADDR_W-1:0];
              pwdata_q <= cmd_wdata;
            end else begin
              // Decode error: answer directly, bus stays quiet.
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end
          end
        end
        StSetup: begin
          state_q   <= StAccess;
          penable_q <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
          to_cnt_q  <= '0;
`endif
        end
        StAccess: begin
          if (sel_pready) begin
            state_q     <= StResp;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= sel_pslverr;
            rsp_rdata_q <= (!pwrite_q && !sel_pslverr) ? sel_prdata : '0;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (to_cnt_q == ToLast) begin
            state_q     <= StResp;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
`endif
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Gated with PRESET so every output reads 0 while reset is held.
  assign cmd_ready = (state_q == StIdle) && !PRESET;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
module tb_apb_master_ctrl;

  localparam int unsigned NSLV = 3;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [9:0]    cmd_addr;
  logic [31:0]   cmd_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [NSLV-1:0] PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [7:0]    PADDR;
  logic [31:0]   PWDATA;
  logic [32*NSLV-1:0] PRDATA;
  logic [NSLV-1:0] PREADY;
  logic [NSLV-1:0] PSLVERR;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t exp_q[$];
  int n_pass = 0;
  int n_total = 0;
  int n_pulses = 0;
  int n_exp_pulses = 0;

  apb_master_ctrl #(
    .NUM_SLV     (NSLV),
    .SEL_W       (2),
    .TIMEOUT_CYC (8)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  always @(negedge PCLK) begin
    if (rsp_valid === 1'b1) n_pulses = n_pulses + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " PSEL"}, 32'(PSEL), 32'd0);
    chk({tag, " PENABLE"}, 32'(PENABLE), 32'd0);
    chk({tag, " PWRITE"}, 32'(PWRITE), 32'd0);
    chk({tag, " PADDR"}, 32'(PADDR), 32'd0);
    chk({tag, " PWDATA"}, PWDATA, 32'd0);
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, " rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, " rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, " cmd_ready"}, 32'(cmd_ready), 32'd0);
  endtask

  // Called at a negedge where the block should be idle; drives the command in that
  // cycle (cycle 0) and returns at the negedge after the response, with cmd_ready
  // checked high there.
  task automatic run_cmd(input string tag, input logic wr, input logic [1:0] idx,
                         input logic [7:0] addr, input logic [31:0] wd, input int waits,
                         input bit give_ready, input logic exp_err,
                         input logic [31:0] exp_rd);
    logic [NSLV-1:0] oh;
    bit              last;
    rsp_t            e;
    oh = NSLV'(1 << idx);
    chk({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = {idx, addr};
    cmd_wdata = wd;
    exp_q.push_back('{err: exp_err, rdata: exp_rd});
    n_exp_pulses = n_exp_pulses + 1;
    @(negedge PCLK);
    // Scramble command inputs; they must be ignored outside IDLE.
    cmd_valid = 1'b0;
    cmd_write = ~wr;
    cmd_addr  = ~{idx, addr};
    cmd_wdata = ~wd;
    if (32'(idx) < NSLV) begin
      chk({tag, " setup PSEL"}, 32'(PSEL), 32'(oh));
      chk({tag, " setup PENABLE"}, 32'(PENABLE), 32'd0);
      chk({tag, " setup PWRITE"}, 32'(PWRITE), 32'(wr));
      chk({tag, " setup PADDR"}, 32'(PADDR), 32'(addr));
      chk({tag, " setup PWDATA"}, PWDATA, wd);
      chk({tag, " setup cmd_ready"}, 32'(cmd_ready), 32'd0);
      @(negedge PCLK);
      for (int w = 0; w <= waits; w++) begin
        last = give_ready && (w == waits);
        chk({tag, " access PENABLE"}, 32'(PENABLE), 32'd1);
        chk({tag, " access PSEL"}, 32'(PSEL), 32'(oh));
        chk({tag, " access PADDR"}, 32'(PADDR), 32'(addr));
        chk({tag, " access PWDATA"}, PWDATA, wd);
        chk({tag, " access rsp_valid"}, 32'(rsp_valid), 32'd0);
        // Unselected slaves always claim ready and error; they must be ignored.
        PREADY  = last ? '1 : ~oh;
        PSLVERR = (last && !exp_err) ? ~oh : '1;
        @(negedge PCLK);
      end
      PREADY  = '0;
      PSLVERR = '0;
    end
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    if (rsp_valid === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, " rsp_err"}, 32'(rsp_err), 32'(e.err));
      chk({tag, " rsp_rdata"}, rsp_rdata, e.rdata);
    end
    chk({tag, " rsp PSEL"}, 32'(PSEL), 32'd0);
    chk({tag, " rsp PENABLE"}, 32'(PENABLE), 32'd0);
    @(negedge PCLK);
    chk({tag, " post rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, " post cmd_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    bit stuck_ok;
    int hold;
    PRESET    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    PREADY    = '0;
    PSLVERR   = '0;
    PRDATA    = {32'h0000_1234, 32'h1111_1111, 32'hCAFE_0000};

    @(negedge PCLK);
    @(negedge PCLK);
    chk_all_zero("reset");
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("after reset cmd_ready", 32'(cmd_ready), 32'd1);
    chk("after reset PSEL", 32'(PSEL), 32'd0);

    run_cmd("wr s1", 1'b1, 2'd1, 8'h10, 32'hDEADBEEF, 0, 1'b1, 1'b0, 32'h0);
    run_cmd("rd s2 waits", 1'b0, 2'd2, 8'h44, 32'h0, 3, 1'b1, 1'b0, 32'h0000_1234);
    run_cmd("decode err", 1'b0, 2'd3, 8'h20, 32'h0, 0, 1'b1, 1'b1, 32'h0);
    run_cmd("wr s0 slverr", 1'b1, 2'd0, 8'h04, 32'h5555_AAAA, 0, 1'b1, 1'b1, 32'h0);
    // Issued at cycle 4 of the previous transfer, straight after its response.
    run_cmd("rd s0 b2b", 1'b0, 2'd0, 8'h08, 32'h0, 1, 1'b1, 1'b0, 32'hCAFE_0000);
    run_cmd("rd s1", 1'b0, 2'd1, 8'hFF, 32'h0, 0, 1'b1, 1'b0, 32'h1111_1111);
`ifdef APB_MASTER_TIMEOUT_EN
    run_cmd("timeout", 1'b0, 2'd2, 8'h30, 32'h0, 7, 1'b0, 1'b1, 32'h0);
    hold = 3;
`else
    hold = 100;
`endif

    // Stall in ACCESS, then reset mid-transfer.
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = {2'd1, 8'h5A};
    cmd_wdata = 32'h1357_9BDF;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    stuck_ok = 1'b1;
    for (int c = 0; c < hold; c++) begin
      if (PENABLE !== 1'b1 || rsp_valid !== 1'b0 || PSEL !== 3'b010) stuck_ok = 1'b0;
      @(negedge PCLK);
    end
    chk("held in ACCESS", 32'(stuck_ok), 32'd1);
    #2 PRESET = 1'b1;
    #1 chk_all_zero("mid reset");
    @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("post reset rsp_valid", 32'(rsp_valid), 32'd0);
    run_cmd("wr s2 after reset", 1'b1, 2'd2, 8'h7F, 32'h0BAD_F00D, 2, 1'b1, 1'b0, 32'h0);

    @(negedge PCLK);
    chk("response pulse count", 32'(n_pulses), 32'(n_exp_pulses));
    chk("scoreboard empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
